// File: rtl/dynamic_output_rr_arbiter_pkg.sv
// rtl/dynamic_output_rr_arbiter_pkg.sv - shared types, defaults and config checks for the output-port scheduler
package dynamic_output_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   localparam int DEF_NUM_IN       = 5;
   localparam int DEF_BUFFER_DEPTH = 4;
   localparam int DEF_CREDIT_W     = 3;

   // The counter must be able to hold the full downstream depth.
   function automatic bit credit_width_ok(input int depth, input int width);
      return depth < (1 << width);
   endfunction

endpackage

// File: rtl/dynamic_output_rr_arbiter_rr.sv
// rtl/dynamic_output_rr_arbiter_rr.sv - combinational round-robin picker: first request after ptr wins
module dynamic_output_rr_arbiter_rr #(
   parameter int N  = 5,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic found;

   // Offset i walks ptr+1, ptr+2, ... so the last winner has lowest priority.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j == ((int'(ptr) + 1 + i) % N))) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dynamic_output_rr_arbiter.sv
// rtl/dynamic_output_rr_arbiter.sv - wormhole output scheduler: per-packet rr grant plus yummy credit counter
module dynamic_output_rr_arbiter
   import dynamic_output_rr_arbiter_pkg::*;
#(
   parameter int NUM_IN       = DEF_NUM_IN,
   parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
   parameter int CREDIT_W     = DEF_CREDIT_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_IN-1:0]   route_req_in,
   input  logic [NUM_IN-1:0]   tail_in,
   input  logic [NUM_IN-1:0]   valid_in,
   input  logic                default_ready,
   input  logic                yummy_in,
   output logic [NUM_IN-1:0]   grant_out,
   output logic                valid_out,
   output logic [NUM_IN-1:0]   thanks_out,
   output logic [CREDIT_W-1:0] credits_out,
   output logic                ec_wants_to_send_but_cannot,
   output logic                credit_err
);

   localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam logic [CREDIT_W-1:0] FULL_CREDITS = CREDIT_W'(BUFFER_DEPTH);

   generate
      if (!credit_width_ok(BUFFER_DEPTH, CREDIT_W)) begin : g_bad_cfg
         $error("CREDIT_W too narrow for BUFFER_DEPTH");
      end
   endgenerate

   state_e              state_q, state_d;
   logic [NUM_IN-1:0]   owner_q, owner_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic                credit_err_q, credit_err_d;

   logic [NUM_IN-1:0]   arb_gnt;
   logic [PW-1:0]       win_idx;
   logic                locked, owner_has_flit, owner_tail, send;

   dynamic_output_rr_arbiter_rr #(.N(NUM_IN), .PW(PW)) u_rr (
      .req (route_req_in & valid_in),
      .ptr (ptr_q),
      .gnt (arb_gnt)
   );

   always_comb begin
      win_idx = '0;
      for (int j = 0; j < NUM_IN; j++) begin
         if (arb_gnt[j]) win_idx = PW'(j);
      end
   end

   // Send qualification uses only the registered credit count, never yummy_in.
   assign locked         = (state_q == ST_LOCKED);
   assign owner_has_flit = |(owner_q & valid_in);
   assign owner_tail     = |(owner_q & tail_in);
   assign send           = locked && owner_has_flit && (credits_q != '0);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      ptr_d        = ptr_q;
      credits_d    = credits_q;
      credit_err_d = credit_err_q;

      case (state_q)
         ST_IDLE: begin
            if (default_ready && (|arb_gnt)) begin
               state_d = ST_LOCKED;
               owner_d = arb_gnt;
               ptr_d   = win_idx;
            end
         end
         ST_LOCKED: begin
            if (send && owner_tail) begin
               state_d = ST_IDLE;
               owner_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = '0;
         end
      endcase

      case ({yummy_in, send})
         2'b10: begin
            if (credits_q == FULL_CREDITS) credit_err_d = 1'b1;
            else                           credits_d    = credits_q + CREDIT_W'(1);
         end
         2'b01:   credits_d = credits_q - CREDIT_W'(1);
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         ptr_q        <= PW'(NUM_IN - 1);
         credits_q    <= FULL_CREDITS;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         ptr_q        <= ptr_d;
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign grant_out                   = owner_q;
   assign valid_out                   = send;
   assign thanks_out                  = owner_q & {NUM_IN{send}};
   assign credits_out                 = credits_q;
   assign ec_wants_to_send_but_cannot = locked && owner_has_flit && (credits_q == '0);
   assign credit_err                  = credit_err_q;

endmodule
